// File: rtl/fixed_point_pkg.sv
// Shared fixed-point parameters and state encoding for the Q8.4 vector datapath.
// Derived widths size the sum-of-squares and square-root paths so they cannot overflow.
package fixed_point_pkg;

    localparam int WIDTH = 12;
    localparam int FRAC  = 4;
    localparam int SUMW  = 2 * WIDTH + 1;
    localparam int LENW  = WIDTH + 1;
    localparam int ONE   = 1 << FRAC;

    typedef enum logic [2:0] {
        IDLE,
        SUMSQ,
        SQRT,
        DIV,
        DONE
    } state_t;

endpackage

// File: rtl/fixed_point_sqrt_seq.sv
// Bit-serial restoring integer square root, one root bit per cycle, MSB first.
// done is high during the cycle whose clock edge produces the final root bit.
module fixed_point_sqrt_seq #(
    parameter int LENW = fixed_point_pkg::LENW,
    parameter int SUMW = 2 * LENW - 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SUMW-1:0] radicand,
    output logic            done,
    output logic [LENW-1:0] root
);
    import fixed_point_pkg::*;

    localparam int RADW  = 2 * LENW;
    localparam int REMW  = LENW + 2;
    localparam int CNT_W = $clog2(LENW);

    logic [RADW-1:0]  rad;
    logic [REMW-1:0]  rem;
    logic [REMW-1:0]  rem_shift;
    logic [REMW-1:0]  trial;
    logic [LENW-1:0]  root_q;
    logic [CNT_W-1:0] cnt;
    logic             running;
    logic             fits;

    // Bring the next two radicand bits into the remainder and try (4*root + 1).
    always_comb begin
        rem_shift = (rem << 2) | {{(REMW - 2){1'b0}}, rad[RADW-1 -: 2]};
        trial     = {root_q, 2'b01};
        fits      = rem_shift >= trial;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad     <= '0;
            rem     <= '0;
            root_q  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            rad     <= {{(RADW - SUMW){1'b0}}, radicand};
            rem     <= '0;
            root_q  <= '0;
            cnt     <= CNT_W'(LENW - 1);
            running <= 1'b1;
        end else if (running) begin
            rad    <= rad << 2;
            rem    <= fits ? rem_shift - trial : rem_shift;
            root_q <= (root_q << 1) | {{(LENW - 1){1'b0}}, fits};
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = running && (cnt == '0);
    assign root = root_q;

endmodule

// File: rtl/fixed_vec3_normalize_seq.sv
// Sequential Q8.4 vec3 normalizer: exact sum of squares, serial sqrt, then
// three 5-step restoring divisions (x, y, z) sharing one remainder/quotient pair.
module fixed_vec3_normalize_seq #(
    parameter int WIDTH = fixed_point_pkg::WIDTH,
    parameter int FRAC  = fixed_point_pkg::FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic [WIDTH-1:0] in_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] out_z,
    output logic             out_zero,
    output logic             busy
);
    import fixed_point_pkg::*;

    localparam int SUM_W = 2 * WIDTH + 1;
    localparam int LEN_W = WIDTH + 1;
    localparam int REM_W = LEN_W + 1;
    localparam int Q_W   = FRAC + 1;
    localparam int IT_W  = $clog2(FRAC + 1);
    localparam logic [IT_W-1:0] LAST_IT = IT_W'(FRAC);

    state_t            state;
    logic [WIDTH-1:0]  mag_x, mag_y, mag_z;
    logic              sign_x, sign_y, sign_z;
    logic [SUM_W-1:0]  sum_sq;
    logic [LEN_W-1:0]  len;
    logic              sqrt_start;
    logic              sqrt_done;

    logic [REM_W-1:0]  div_rem;
    logic [Q_W-1:0]    div_quot;
    logic [IT_W-1:0]   div_iter;
    logic [1:0]        div_comp;

    logic              div_ge;
    logic [REM_W-1:0]  div_diff;
    logic [Q_W-1:0]    q_next;
    logic [WIDTH-1:0]  q_ext;
    logic              cur_sign;
    logic [WIDTH-1:0]  next_mag;
    logic [WIDTH-1:0]  div_result;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign sum_sq = SUM_W'(mag_x) * SUM_W'(mag_x)
                  + SUM_W'(mag_y) * SUM_W'(mag_y)
                  + SUM_W'(mag_z) * SUM_W'(mag_z);

    assign sqrt_start = (state == SUMSQ) && (sum_sq != '0);

    fixed_point_sqrt_seq #(
        .LENW (LEN_W),
        .SUMW (SUM_W)
    ) u_sqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sqrt_start),
        .radicand (sum_sq),
        .done     (sqrt_done),
        .root     (len)
    );

    // Remainder never reaches 2*len because |c| <= len, so no quotient bit exceeds 16.
    always_comb begin
        div_ge     = div_rem >= REM_W'(len);
        div_diff   = div_ge ? div_rem - REM_W'(len) : div_rem;
        q_next     = (div_quot << 1) | Q_W'(div_ge);
        q_ext      = WIDTH'(q_next);
        cur_sign   = sign_z;
        next_mag   = mag_x;
        case (div_comp)
            2'd0: begin
                cur_sign = sign_x;
                next_mag = mag_y;
            end
            2'd1: begin
                cur_sign = sign_y;
                next_mag = mag_z;
            end
            default: begin
                cur_sign = sign_z;
                next_mag = mag_x;
            end
        endcase
        div_result = cur_sign ? -q_ext : q_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mag_x     <= '0;
            mag_y     <= '0;
            mag_z     <= '0;
            sign_x    <= 1'b0;
            sign_y    <= 1'b0;
            sign_z    <= 1'b0;
            div_rem   <= '0;
            div_quot  <= '0;
            div_iter  <= '0;
            div_comp  <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_z     <= '0;
            out_zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mag_x    <= magnitude(in_x);
                        mag_y    <= magnitude(in_y);
                        mag_z    <= magnitude(in_z);
                        sign_x   <= in_x[WIDTH-1];
                        sign_y   <= in_y[WIDTH-1];
                        sign_z   <= in_z[WIDTH-1];
                        out_zero <= 1'b0;
                        state    <= SUMSQ;
                    end
                end
                SUMSQ: begin
                    if (sum_sq == '0) begin
                        out_x    <= '0;
                        out_y    <= '0;
                        out_z    <= '0;
                        out_zero <= 1'b1;
                        state    <= DONE;
                    end else begin
                        state <= SQRT;
                    end
                end
                SQRT: begin
                    if (sqrt_done) begin
                        div_rem  <= REM_W'(mag_x);
                        div_quot <= '0;
                        div_iter <= '0;
                        div_comp <= '0;
                        state    <= DIV;
                    end
                end
                DIV: begin
                    if (div_iter == LAST_IT) begin
                        case (div_comp)
                            2'd0:    out_x <= div_result;
                            2'd1:    out_y <= div_result;
                            default: out_z <= div_result;
                        endcase
                        div_rem  <= REM_W'(next_mag);
                        div_quot <= '0;
                        div_iter <= '0;
                        if (div_comp == 2'd2) begin
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            div_comp <= div_comp + 2'd1;
                        end
                    end else begin
                        div_rem  <= div_diff << 1;
                        div_quot <= q_next;
                        div_iter <= div_iter + 1'b1;
                    end
                end
                DONE: begin
                    // The zero-vector shortcut arrives here with out_valid still low.
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule
